clk_div_multi: RTL

Multi-channel programmable clock divider and tick generator: CH independent channels each produce a divided square wave and a one-cycle terminal-count tick from the system clock. Period and low-phase length are runtime-programmable through a shadowed configuration port and take effect glitch-free at period boundaries. Sits between the board oscillator and slow logic (display scan, debouncers, 1 Hz timekeeping), replacing fixed single-rate dividers.

---
 rtl/clk_div_multi.sv | 75 +++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable divider/tick generator; define CLKDIV_DUTY_EN for a programmable low length per channel
module clk_div_multi #(
  parameter int W = 26,
  parameter int CH = 4,
  parameter int unsigned DEF_PERIOD = 49999999,
  parameter int unsigned DEF_LOW = 25000000,
  localparam int CW = CH > 1 ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] en,
  input  logic          sync,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_period,
  input  logic [W-1:0]  cfg_low,
  output logic [CH-1:0] clk_out,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] pending
);
`ifndef CLKDIV_DUTY_EN
  logic unused_low;
  assign unused_low = ^{cfg_low, W'(DEF_LOW)};
`endif
  for (genvar g = 0; g < CH; g++) begin : gen_ch
    logic [W-1:0] cnt, per, sper, cnt_n, per_n, low_n;
    logic pnd, co, tk, wr, wrap, apply;
`ifdef CLKDIV_DUTY_EN
    logic [W-1:0] dl, sdl, dl_n;
`endif
    assign wr = cfg_we && cfg_ch == CW'(g);
    // Period restart (natural wrap or sync) is where shadows land; a disabled channel takes them at once and idles at its terminal count
    always_comb begin
      wrap = en[g] && (sync || cnt == per);
      apply = pnd && (wrap || !en[g]);
      per_n = apply ? sper : per;
      cnt_n = !en[g] ? per_n : wrap ? '0 : cnt + W'(1);
`ifdef CLKDIV_DUTY_EN
      dl_n = apply ? sdl : dl;
      low_n = dl_n;
`else
      low_n = (per_n >> 1) + W'(per_n[0]);
`endif
    end
    // Outputs are derived from the next count so they line up with cnt
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= W'(DEF_PERIOD);
        per <= W'(DEF_PERIOD);
        sper <= W'(DEF_PERIOD);
        pnd <= 1'b0;
        co <= 1'b0;
        tk <= 1'b0;
`ifdef CLKDIV_DUTY_EN
        dl <= W'(DEF_LOW);
        sdl <= W'(DEF_LOW);
`endif
      end else begin
        cnt <= cnt_n;
        per <= per_n;
        pnd <= wr || (pnd && !apply);
        if (wr) sper <= cfg_period;
        co <= en[g] && cnt_n >= low_n;
        tk <= en[g] && cnt_n == per_n;
`ifdef CLKDIV_DUTY_EN
        dl <= dl_n;
        if (wr) sdl <= cfg_low;
`endif
      end
    end
    assign clk_out[g] = co;
    assign tick[g] = tk;
    assign pending[g] = pnd;
  end
endmodule
